// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the instruction decoder and the multiply/divide unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mips_pkg;

  // HI/LO operation select as produced by the decoder.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_t;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_RUN   = 2'b01,
    MD_FIXUP = 2'b10
  } mdState_t;

  function automatic logic isDivOp(input mdOp_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isSignedOp(input mdOp_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage request/response bundle between the pipeline and the HI/LO unit.
// Latency: wires only.
// Backpressure: MdStall from the unit holds EX while an operation is in flight.
//   master (pipeline): drives Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX
//   slave  (unit)    : drives Hi, Lo, Busy, Done, MdStall
interface muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             Start_EX;
  mdOp_t            Op_EX;
  logic [WIDTH-1:0] SrcA_EX;
  logic [WIDTH-1:0] SrcB_EX;
  logic             ReadHiLo_EX;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             MdStall;

  modport master (
    output Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX,
    input  Hi, Lo, Busy, Done, MdStall
  );

  modport slave (
    input  Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX,
    output Hi, Lo, Busy, Done, MdStall
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the {high/remainder, low} register pair.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
//   isDiv        : 1 = restoring shift-subtract, 0 = shift-add multiply
//   hiIn/loIn    : current register pair (partial product / partial remainder+quotient)
//   opnd         : multiplicand magnitude or divisor magnitude
//   hiOut/loOut  : register pair after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] hiIn,
  input  logic [WIDTH-1:0] loIn,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  logic [WIDTH:0]   sum;      // high half plus optional multiplicand, with carry
  logic [WIDTH:0]   shifted;  // partial remainder after pulling in the next dividend bit
  logic [WIDTH-1:0] diff;
  logic             fits;     // divisor fits into the shifted partial remainder

  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB (in loIn[0]) is set,
    // then shift the whole {carry, hi, lo} right by one. The consumed multiplier
    // bit falls off the bottom while product bits enter from the top.
    sum = {1'b0, hiIn} + (loIn[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: shift {rem, lo} left by one. The remainder is always below the
    // divisor, so when the divisor fits the difference fits in WIDTH bits and
    // the wrapped WIDTH-bit subtraction is exact.
    shifted = {hiIn, loIn[WIDTH-1]};
    fits    = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;

    if (isDiv) begin
      hiOut = fits ? diff : shifted[WIDTH-1:0];
      loOut = {loIn[WIDTH-2:0], fits};
    end else begin
      hiOut = sum[WIDTH:1];
      loOut = {sum[0], loIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Latency: WIDTH+2 edges from the Start_EX sampling edge (inclusive) to Hi/Lo valid; Done pulses then.
// Backpressure: MdStall = Busy & (Start_EX | ReadHiLo_EX); a Start_EX while busy is dropped.
//   clk, reset (async, active-high), flush (sync abort, beats Start_EX)
//   md.* : request (Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX) and
//          response (Hi, Lo, Busy, Done, MdStall); WIDTH must be even and >= 8.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  muldiv_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdState_t         state;
  mdState_t         stateNext;
  logic [CW-1:0]    stepCnt;
  logic             lastStep;

  // Latched operation and working registers.
  mdOp_t            opReg;
  logic             divOp;
  logic [WIDTH-1:0] opndReg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] accHi;     // partial product high / partial remainder
  logic [WIDTH-1:0] accLo;     // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic             negProd;
  logic             negQuo;
  logic             negRem;

  // Architectural results.
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             doneReg;

  // FSM outputs.
  logic             busy;
  logic             loadOp;
  logic             stepEn;
  logic             writeRes;

  // Operand capture.
  logic             signA;
  logic             signB;
  logic             startDiv;
  logic             divByZero;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  // Sign fixup.
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  assign lastStep = (stepCnt == CW'(WIDTH - 1));

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE:  if (md.Start_EX) stateNext = MD_RUN;
      MD_RUN:   if (lastStep)    stateNext = MD_FIXUP;
      MD_FIXUP: stateNext = MD_IDLE;
      default:  stateNext = MD_IDLE;
    endcase
    if (flush) stateNext = MD_IDLE;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state != MD_IDLE);
    loadOp   = 1'b0;
    stepEn   = 1'b0;
    writeRes = 1'b0;
    case (state)
      MD_IDLE:  loadOp   = md.Start_EX & ~flush;
      MD_RUN:   stepEn   = ~flush;
      MD_FIXUP: writeRes = ~flush;   // a flushed fixup neither writes nor signals Done
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stepCnt <= '0;
    end else if (loadOp) begin
      stepCnt <= '0;
    end else if (stepEn) begin
      stepCnt <= stepCnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture: iterate on magnitudes, remember which results to negate.
  // The most negative value negates to itself, which is its correct unsigned
  // magnitude, so no special case is needed for it.
  // ---------------------------------------------------------------------------
  always_comb begin
    startDiv  = isDivOp(md.Op_EX);
    signA     = isSignedOp(md.Op_EX) & md.SrcA_EX[WIDTH-1];
    signB     = isSignedOp(md.Op_EX) & md.SrcB_EX[WIDTH-1];
    magA      = signA ? -md.SrcA_EX : md.SrcA_EX;
    magB      = signB ? -md.SrcB_EX : md.SrcB_EX;
    divByZero = (md.SrcB_EX == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg   <= MD_MULT;
      opndReg <= '0;
      accHi   <= '0;
      accLo   <= '0;
      negProd <= 1'b0;
      negQuo  <= 1'b0;
      negRem  <= 1'b0;
    end else if (loadOp) begin
      opReg <= md.Op_EX;
      accHi <= '0;
      if (startDiv) begin
        accLo   <= magA;
        opndReg <= magB;
      end else begin
        accLo   <= magB;
        opndReg <= magA;
      end
      negProd <= ~startDiv & (signA ^ signB);
      // Divide by zero leaves an all-ones quotient that must not be negated;
      // the remainder is |A| and its sign restore gives back the original A.
      negQuo  <= startDiv & (signA ^ signB) & ~divByZero;
      negRem  <= startDiv & signA;
    end else if (stepEn) begin
      accHi <= stepHi;
      accLo <= stepLo;
    end
  end

  assign divOp = isDivOp(opReg);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .isDiv (divOp),
    .hiIn  (accHi),
    .loIn  (accLo),
    .opnd  (opndReg),
    .hiOut (stepHi),
    .loOut (stepLo)
  );

  // ---------------------------------------------------------------------------
  // Sign fixup and HI/LO write-back
  // ---------------------------------------------------------------------------
  always_comb begin
    prodRaw = {accHi, accLo};
    prodFix = negProd ? -prodRaw : prodRaw;
    quoFix  = negQuo ? -accLo : accLo;
    remFix  = negRem ? -accHi : accHi;
    if (divOp) begin
      resHi = remFix;
      resLo = quoFix;
    end else begin
      resHi = prodFix[2*WIDTH-1:WIDTH];
      resLo = prodFix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= writeRes;
      if (writeRes) begin
        hiReg <= resHi;
        loReg <= resLo;
      end
    end
  end

  assign md.Hi      = hiReg;
  assign md.Lo      = loReg;
  assign md.Busy    = busy;
  assign md.Done    = doneReg;
  assign md.MdStall = busy & (md.Start_EX | md.ReadHiLo_EX);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// Stimulus pushes reference results into a queue; a negedge monitor pops on Done.
// Directed corner cases, randomized operations, stall, flush and reset scenarios.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  muldiv_unit_if #(.WIDTH(W)) mdIf ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .md    (mdIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sbQ[$];
  exp_t         monE;
  int           checks    = 0;
  int           errors    = 0;
  int           doneCount = 0;
  logic [W-1:0] lastHi    = '0;
  logic [W-1:0] lastLo    = '0;

  // Reference model: plain integer arithmetic, MIPS truncating division.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int          sa = a;
    int          sb = b;
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && mdIf.Done === 1'b1) begin
      doneCount++;
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Hi=%h Lo=%h expected no result", mdIf.Hi, mdIf.Lo);
      end else begin
        monE = sbQ.pop_front();
        if (mdIf.Hi !== monE.hi || mdIf.Lo !== monE.lo) begin
          errors++;
          $display("FAIL result op=%0d a=%h b=%h: got Hi=%h Lo=%h expected Hi=%h Lo=%h",
                   monE.op, monE.a, monE.b, mdIf.Hi, mdIf.Lo, monE.hi, monE.lo);
        end
      end
    end
  end

  // Drive a one-cycle Start_EX; returns at the negedge after the sampling edge.
  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    mdIf.Start_EX = 1'b1;
    mdIf.Op_EX    = mdOp_t'(op);
    mdIf.SrcA_EX  = a;
    mdIf.SrcB_EX  = b;
    @(negedge clk);
    mdIf.Start_EX = 1'b0;
  endtask

  task automatic issueExp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.hi = hi; e.lo = lo;
    sbQ.push_back(e);
    lastHi = hi;
    lastLo = lo;
    startOp(op, a, b);
  endtask

  // Edges counted inclusively from the Start_EX sampling edge.
  task automatic waitDone(output int lat, output int busyCyc);
    lat     = 1;
    busyCyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (mdIf.Done === 1'b1) break;
      if (mdIf.Busy === 1'b1) busyCyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (mdIf.Done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done after %0d edges expected Done", lat);
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo);
    int lat;
    int busyCyc;
    issueExp(op, a, b, hi, lo);
    waitDone(lat, busyCyc);
    check("latency", 64'(lat), 64'(W + 2));
    check("busy_cycles", 64'(busyCyc), 64'(W + 1));
  endtask

  task automatic runModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = model(op, a, b);
    runOp(op, a, b, r[2*W-1:W], r[W-1:0]);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busyCyc;
    int d0;
    logic [2*W-1:0] r;

    reset            = 1'b1;
    flush            = 1'b0;
    mdIf.Start_EX    = 1'b0;
    mdIf.Op_EX       = MD_MULT;
    mdIf.SrcA_EX     = '0;
    mdIf.SrcB_EX     = '0;
    mdIf.ReadHiLo_EX = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(mdIf.Hi), 64'h0);
    check("reset_lo", 64'(mdIf.Lo), 64'h0);
    check("reset_busy", 64'(mdIf.Busy), 64'h0);
    check("reset_done", 64'(mdIf.Done), 64'h0);
    check("reset_stall", 64'(mdIf.MdStall), 64'h0);
    mdIf.ReadHiLo_EX = 1'b0;
    reset            = 1'b0;

    // Directed corner cases.
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    runOp(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MFHI/MFLO in IDLE: no stall, current values visible.
    @(negedge clk);
    mdIf.ReadHiLo_EX = 1'b1;
    #1;
    check("idle_read_stall", 64'(mdIf.MdStall), 64'h0);
    check("idle_read_hi", 64'(mdIf.Hi), 64'(lastHi));
    check("idle_read_lo", 64'(mdIf.Lo), 64'(lastLo));
    mdIf.ReadHiLo_EX = 1'b0;

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      runModel(2'($urandom_range(0, 3)), pick(), pick());
    end

    // Stall on MFHI during MULT; a second Start while busy is ignored.
    r = model(2'b00, 32'd12345, 32'hFFFF_FD5A);
    issueExp(2'b00, 32'd12345, 32'hFFFF_FD5A, r[2*W-1:W], r[W-1:0]);
    repeat (4) @(negedge clk);
    mdIf.ReadHiLo_EX = 1'b1;
    #1;
    check("busy_read_stall", 64'(mdIf.MdStall), 64'h1);
    @(negedge clk);
    mdIf.ReadHiLo_EX = 1'b0;
    mdIf.Start_EX    = 1'b1;
    mdIf.Op_EX       = MD_MULTU;
    mdIf.SrcA_EX     = 32'd5;
    mdIf.SrcB_EX     = 32'd6;
    #1;
    check("busy_start_stall", 64'(mdIf.MdStall), 64'h1);
    @(negedge clk);
    mdIf.Start_EX = 1'b0;
    waitDone(lat, busyCyc);
    #1;
    d0 = doneCount;
    repeat (40) @(negedge clk);
    check("ignored_start_no_done", 64'(doneCount), 64'(d0));
    check("ignored_start_hi", 64'(mdIf.Hi), 64'(r[2*W-1:W]));
    check("ignored_start_lo", 64'(mdIf.Lo), 64'(r[W-1:0]));

    // Flush mid-DIV leaves Hi/Lo and suppresses Done.
    runOp(2'b11, 32'h0000_2211, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022);
    startOp(2'b10, 32'h1234_5678, 32'h0000_0035);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(mdIf.Busy), 64'h0);
    check("flush_hi", 64'(mdIf.Hi), 64'h11);
    check("flush_lo", 64'(mdIf.Lo), 64'h22);
    #1;
    d0 = doneCount;
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(doneCount), 64'(d0));
    check("flush_hi_after", 64'(mdIf.Hi), 64'h11);

    // Flush beats Start in IDLE.
    @(negedge clk);
    flush         = 1'b1;
    mdIf.Start_EX = 1'b1;
    mdIf.Op_EX    = MD_DIVU;
    @(negedge clk);
    flush         = 1'b0;
    mdIf.Start_EX = 1'b0;
    check("flush_over_start_busy", 64'(mdIf.Busy), 64'h0);

    // Reset mid-MULTU.
    startOp(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_hi", 64'(mdIf.Hi), 64'h0);
    check("midreset_lo", 64'(mdIf.Lo), 64'h0);
    check("midreset_busy", 64'(mdIf.Busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    d0 = doneCount;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 64'(doneCount), 64'(d0));
    check("midreset_busy_after", 64'(mdIf.Busy), 64'h0);

    // Unit still operational afterwards.
    runOp(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbQ.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, Hi and Lo width; SHALL be even and >= 8.
REQ-002 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1: asynchronous, active-high reset.
REQ-004 Port flush  input  1: synchronous pipeline flush; aborts any operation in progress.
REQ-005 Port Start_EX  input  1: request to begin the operation given by Op_EX.
REQ-006 Port Op_EX  input  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port SrcA_EX  input  WIDTH: multiplicand or dividend (bypassed rs value).
REQ-008 Port SrcB_EX  input  WIDTH: multiplier or divisor (bypassed rt value).
REQ-009 Port ReadHiLo_EX  input  1: an MFHI or MFLO instruction is in EX this cycle.
REQ-010 Port Hi  output  WIDTH: product upper half or remainder.
REQ-011 Port Lo  output  WIDTH: product lower half or quotient.
REQ-012 Port Busy  output  1: high whenever the state is not IDLE.
REQ-013 Port Done  output  1: one-cycle pulse, high in the first cycle in which a new Hi and Lo are visible.
REQ-014 Port MdStall  output  1: combinational stall request to the hazard unit.

Function
REQ-015 The unit SHALL use a three-state FSM: IDLE, RUN, FIXUP.
REQ-016 In IDLE, Start_EX=1 SHALL latch Op_EX, |SrcA_EX|, |SrcB_EX| (absolute value for signed ops, raw for unsigned ops) and the result signs, clear the step counter, and go to RUN.
REQ-017 RUN SHALL perform exactly one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 RUN SHALL last exactly WIDTH cycles, then go to FIXUP.
REQ-019 The step counter SHALL be $clog2(WIDTH)+1 bits wide, with terminal count WIDTH-1.
REQ-020 FIXUP SHALL negate the results for signed ops: the 2*WIDTH product when the operand signs differ, the quotient when the signs differ, and the remainder when the dividend is negative.
REQ-021 FIXUP SHALL write Hi and Lo, go to IDLE, and assert Done in the following cycle.
REQ-022 Latency from the Start_EX sampling edge to Hi/Lo valid SHALL be WIDTH+2 edges (34 for WIDTH=32).
REQ-023 Divide by zero (DIV or DIVU) SHALL run full latency and produce Hi = original SrcA and Lo = all ones.
REQ-024 Signed DIV of the most negative value by -1 SHALL produce Lo = most negative value and Hi = 0.
REQ-025 Start_EX while Busy SHALL be ignored.
REQ-026 MdStall SHALL equal Busy & (Start_EX | ReadHiLo_EX).
REQ-027 Start_EX and ReadHiLo_EX in IDLE SHALL cause no stall; MFHI/MFLO then reads the current Hi/Lo.
REQ-028 flush SHALL force IDLE at the next edge, leave Hi/Lo unchanged and suppress Done; flush takes priority over Start_EX.
REQ-029 Hi and Lo SHALL change only in FIXUP or on reset.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0, and clear all latched operands.
REQ-031 Reset asserted mid-operation SHALL discard the operation; no Done SHALL follow deassertion.

Structure
REQ-032 The Op_EX encodings and the FSM state encoding SHALL live in the shared mips_pkg package, which is shared with the decoder.
REQ-033 One combinational sub-module, muldiv_step, SHALL compute a single shift-add or shift-subtract iteration on the {remainder/high, low} register pair.
REQ-034 The FSM, counter, sign fixup and Hi/Lo registers SHALL reside in muldiv_unit.

Verification (WIDTH=32)
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, Done exactly 34 edges after Start, Busy high for 33 cycles.
REQ-036 MULT -3 x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-037 DIVU 7 / 0 -> Hi=0x00000007, Lo=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000.
REQ-038 ReadHiLo_EX=1 at cycle 5 of a MULT -> MdStall=1; second Start_EX at cycle 6 -> ignored; the first result is unaffected.
REQ-039 flush at cycle 10 of a DIV with prior Hi=0x11, Lo=0x22 -> Busy=0 the next cycle, Hi/Lo stay 0x11/0x22, no Done.
REQ-040 reset pulse at cycle 20 of a MULTU -> Hi=Lo=0 immediately, Busy=0, no Done after release.
